// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: PS/2 key decode, IDLE/INIT/PAUSE/RUN/OVER control,
// buffered turn requests and survival score for the movement datapath.
module snake_game_ctrl #(
   parameter int QDEPTH  = 2,
   parameter int SCORE_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_valid,
   input  logic [7:0]         key_code,
   input  logic               tick,
   input  logic               collision,
   output logic               step,
   output logic [1:0]         dir,
   output logic [1:0]         mode,
   output logic               game_over,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         q_count
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_PAUSE, S_RUN, S_OVER} state_t;

   localparam logic [1:0] D_DOWN  = 2'd0, D_UP = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
   localparam logic [1:0] M_RUN   = 2'd0, M_PAUSE = 2'd1, M_BLANK = 2'd2, M_RELOAD = 2'd3;

   state_t                  state, state_nxt;
   logic                    brk, ext;
   logic [QDEPTH-1:0][1:0]  q, q_nxt;
   logic [2:0]              cnt, cnt_nxt;

   logic       is_pfx, is_make;
   logic       k_s, k_r, k_p, k_esc, arrow_vld;
   logic [1:0] arrow_dir;
   logic       do_step, do_pop, reload, arrow_ok, push;
   logic [1:0] step_mode, ref_dir;

   function automatic logic [1:0] mode_of(state_t s);
      case (s)
         S_RUN:   mode_of = M_RUN;
         S_INIT:  mode_of = M_RELOAD;
         S_IDLE:  mode_of = M_BLANK;
         default: mode_of = M_PAUSE;
      endcase
   endfunction

   // Arrows ignore the E0 prefix; E0-prefixed command codes are different keys.
   always_comb begin
      is_pfx    = key_valid && (key_code == 8'hE0 || key_code == 8'hF0);
      is_make   = key_valid && !is_pfx && !brk;
      k_s       = 1'b0;
      k_r       = 1'b0;
      k_p       = 1'b0;
      k_esc     = 1'b0;
      arrow_vld = 1'b0;
      arrow_dir = D_DOWN;
      if (is_make) begin
         case (key_code)
            8'h75: begin arrow_vld = 1'b1; arrow_dir = D_UP;    end
            8'h72: begin arrow_vld = 1'b1; arrow_dir = D_DOWN;  end
            8'h6B: begin arrow_vld = 1'b1; arrow_dir = D_LEFT;  end
            8'h74: begin arrow_vld = 1'b1; arrow_dir = D_RIGHT; end
            8'h1B: k_s   = !ext;
            8'h2D: k_r   = !ext;
            8'h4D: k_p   = !ext;
            8'h76: k_esc = !ext;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      do_step   = 1'b0;
      do_pop    = 1'b0;
      reload    = 1'b0;
      step_mode = M_RUN;
      arrow_ok  = 1'b0;
      case (state)
         S_IDLE: if (k_s) state_nxt = S_INIT;
         S_INIT: if (tick) begin
            do_step   = 1'b1;
            reload    = 1'b1;
            step_mode = M_RELOAD;
            state_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            arrow_ok = 1'b1;
            if (k_r)        state_nxt = S_RUN;
            else if (k_esc) state_nxt = S_IDLE;
            else if (k_s)   state_nxt = S_INIT;
         end
         S_RUN: begin
            arrow_ok = 1'b1;
            if (k_p)        state_nxt = S_PAUSE;
            else if (k_esc) state_nxt = S_IDLE;
            else if (k_s)   state_nxt = S_INIT;
            // A colliding tick wins over any key in the same cycle.
            if (tick && collision) begin
               state_nxt = S_OVER;
               arrow_ok  = 1'b0;
            end else if (tick) begin
               do_step = 1'b1;
               do_pop  = (cnt != 3'd0);
            end
         end
         S_OVER: begin
            if (k_s)        state_nxt = S_INIT;
            else if (k_esc) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Turn filter compares against the newest queued turn, before any pop.
   always_comb begin
      ref_dir = dir;
      for (int i = 0; i < QDEPTH; i++)
         if (cnt == 3'(i + 1)) ref_dir = q[i];
      push = arrow_vld && arrow_ok && (arrow_dir[1] != ref_dir[1]) &&
             (cnt != 3'(QDEPTH));

      q_nxt   = q;
      cnt_nxt = cnt;
      if (do_pop) begin
         for (int i = 0; i < QDEPTH - 1; i++) q_nxt[i] = q[i+1];
         cnt_nxt = cnt - 3'd1;
      end
      if (push) begin
         for (int i = 0; i < QDEPTH; i++)
            if (cnt_nxt == 3'(i)) q_nxt[i] = arrow_dir;
         cnt_nxt = cnt_nxt + 3'd1;
      end
      if (reload) cnt_nxt = 3'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         brk       <= 1'b0;
         ext       <= 1'b0;
         q         <= '0;
         cnt       <= 3'd0;
         step      <= 1'b0;
         dir       <= D_RIGHT;
         mode      <= M_BLANK;
         game_over <= 1'b0;
         score     <= '0;
      end else begin
         if (key_valid) begin
            if (key_code == 8'hE0)      ext <= 1'b1;
            else if (key_code == 8'hF0) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
         state     <= state_nxt;
         q         <= q_nxt;
         cnt       <= cnt_nxt;
         step      <= do_step;
         // The step cycle carries the step's own mode; the new state shows next.
         mode      <= do_step ? step_mode : mode_of(state_nxt);
         game_over <= (state_nxt == S_OVER);
         if (reload) begin
            dir   <= D_RIGHT;
            score <= '0;
         end else if (do_step) begin
            if (do_pop) dir <= q[0];
            if (score != '1) score <= score + 1'b1;
         end
      end
   end

   assign q_count = cnt;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: scenario tasks with hand-computed expectations.
module tb_snake_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       key_valid = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic       tick = 1'b0;
   logic       collision = 1'b0;
   logic       step;
   logic [1:0] dir;
   logic [1:0] mode;
   logic       game_over;
   logic [7:0] score;
   logic [2:0] q_count;

   int total = 0;
   int bad = 0;

   snake_game_ctrl #(.QDEPTH(2), .SCORE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .tick(tick), .collision(collision), .step(step), .dir(dir), .mode(mode),
      .game_over(game_over), .score(score), .q_count(q_count)
   );

   always #5 clk = ~clk;

   task automatic send_key(input logic [7:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic do_tick(input logic coll);
      @(negedge clk);
      tick      = 1'b1;
      collision = coll;
      @(negedge clk);
      tick      = 1'b0;
      collision = 1'b0;
   endtask

   task automatic tick_key(input logic [7:0] c);
      @(negedge clk);
      tick      = 1'b1;
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      tick      = 1'b0;
      key_valid = 1'b0;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      total++; if (step !== 1'b0) begin bad++; $display("FAIL rst_step got %0d want 0", step); end
      total++; if (dir !== 2'd3) begin bad++; $display("FAIL rst_dir got %0d want 3", dir); end
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL rst_mode got %0d want 2", mode); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_go got %0d want 0", game_over); end
      total++; if (score !== 8'd0) begin bad++; $display("FAIL rst_score got %0d want 0", score); end
      total++; if (q_count !== 3'd0) begin bad++; $display("FAIL rst_q got %0d want 0", q_count); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_start_run;
      send_key(8'h2D);
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL idle_ignore mode got %0d want 2", mode); end
      send_key(8'h1B);
      total++; if (mode !== 2'd3) begin bad++; $display("FAIL init_mode got %0d want 3", mode); end
      do_tick(1'b0);
      total++; if (step !== 1'b1) begin bad++; $display("FAIL reload_step got %0d want 1", step); end
      total++; if (mode !== 2'd3) begin bad++; $display("FAIL reload_mode got %0d want 3", mode); end
      total++; if (dir !== 2'd3) begin bad++; $display("FAIL reload_dir got %0d want 3", dir); end
      @(negedge clk);
      total++; if (step !== 1'b0) begin bad++; $display("FAIL step_one_cycle got %0d want 0", step); end
      total++; if (mode !== 2'd1) begin bad++; $display("FAIL pause_mode got %0d want 1", mode); end
      send_key(8'h2D);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL run_mode got %0d want 0", mode); end
      for (int i = 0; i < 3; i++) begin
         do_tick(1'b0);
         total++; if (step !== 1'b1 || mode !== 2'd0) begin bad++; $display("FAIL run_step%0d step=%0d mode=%0d want 1/0", i, step, mode); end
      end
      total++; if (score !== 8'd3) begin bad++; $display("FAIL run_score got %0d want 3", score); end
      total++; if (dir !== 2'd3) begin bad++; $display("FAIL run_dir got %0d want 3", dir); end
   endtask

   task automatic test_queue;
      send_key(8'hE0); send_key(8'h75);
      total++; if (q_count !== 3'd1) begin bad++; $display("FAIL q_up got %0d want 1", q_count); end
      send_key(8'hE0); send_key(8'h6B);
      total++; if (q_count !== 3'd2) begin bad++; $display("FAIL q_left got %0d want 2", q_count); end
      do_tick(1'b0);
      total++; if (dir !== 2'd1 || q_count !== 3'd1) begin bad++; $display("FAIL pop1 dir=%0d q=%0d want 1/1", dir, q_count); end
      do_tick(1'b0);
      total++; if (dir !== 2'd2 || q_count !== 3'd0) begin bad++; $display("FAIL pop2 dir=%0d q=%0d want 2/0", dir, q_count); end
      total++; if (score !== 8'd5) begin bad++; $display("FAIL q_score got %0d want 5", score); end
   endtask

   task automatic test_drop;
      send_key(8'h74);
      total++; if (q_count !== 3'd0) begin bad++; $display("FAIL drop_reverse got %0d want 0", q_count); end
      send_key(8'h6B);
      total++; if (q_count !== 3'd0) begin bad++; $display("FAIL drop_dup got %0d want 0", q_count); end
      send_key(8'h75); send_key(8'h75); send_key(8'h75);
      total++; if (q_count !== 3'd1) begin bad++; $display("FAIL up_x3 got %0d want 1", q_count); end
      do_tick(1'b0);
      total++; if (dir !== 2'd1 || q_count !== 3'd0) begin bad++; $display("FAIL drop_pop dir=%0d q=%0d want 1/0", dir, q_count); end
   endtask

   task automatic test_full;
      send_key(8'h6B); send_key(8'h75); send_key(8'h74);
      total++; if (q_count !== 3'd2) begin bad++; $display("FAIL full_drop got %0d want 2", q_count); end
      do_tick(1'b0);
      total++; if (dir !== 2'd2) begin bad++; $display("FAIL full_pop1 got %0d want 2", dir); end
      do_tick(1'b0);
      total++; if (dir !== 2'd1 || score !== 8'd8) begin bad++; $display("FAIL full_pop2 dir=%0d score=%0d want 1/8", dir, score); end
   endtask

   task automatic test_back_to_back;
      send_key(8'h6B);
      tick_key(8'h75);
      total++; if (step !== 1'b1 || dir !== 2'd2 || q_count !== 3'd1) begin bad++; $display("FAIL popush step=%0d dir=%0d q=%0d want 1/2/1", step, dir, q_count); end
      do_tick(1'b0);
      total++; if (dir !== 2'd1 || q_count !== 3'd0 || score !== 8'd10) begin bad++; $display("FAIL popush2 dir=%0d q=%0d score=%0d want 1/0/10", dir, q_count, score); end
   endtask

   task automatic test_pause;
      send_key(8'hF0); send_key(8'h4D);
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL break_ignored mode got %0d want 0", mode); end
      send_key(8'h4D);
      total++; if (mode !== 2'd1 || game_over !== 1'b0) begin bad++; $display("FAIL pause mode=%0d go=%0d want 1/0", mode, game_over); end
      do_tick(1'b0);
      total++; if (step !== 1'b0) begin bad++; $display("FAIL pause_nostep got %0d want 0", step); end
      send_key(8'h2D);
      do_tick(1'b0);
      total++; if (step !== 1'b1 || score !== 8'd11) begin bad++; $display("FAIL resume step=%0d score=%0d want 1/11", step, score); end
   endtask

   task automatic test_over;
      do_tick(1'b1);
      total++; if (step !== 1'b0) begin bad++; $display("FAIL over_nostep got %0d want 0", step); end
      total++; if (game_over !== 1'b1 || mode !== 2'd1) begin bad++; $display("FAIL over go=%0d mode=%0d want 1/1", game_over, mode); end
      total++; if (score !== 8'd11 || dir !== 2'd1) begin bad++; $display("FAIL over_hold score=%0d dir=%0d want 11/1", score, dir); end
      send_key(8'h2D);
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_r_ignored got %0d want 1", game_over); end
      send_key(8'h1B);
      total++; if (mode !== 2'd3 || game_over !== 1'b0) begin bad++; $display("FAIL over_s mode=%0d go=%0d want 3/0", mode, game_over); end
      do_tick(1'b0);
      total++; if (step !== 1'b1 || score !== 8'd0 || dir !== 2'd3) begin bad++; $display("FAIL over_reload step=%0d score=%0d dir=%0d want 1/0/3", step, score, dir); end
   endtask

   task automatic test_esc_tick;
      send_key(8'h2D);
      tick_key(8'h76);
      total++; if (step !== 1'b1 || mode !== 2'd0 || score !== 8'd1) begin bad++; $display("FAIL esc_tick step=%0d mode=%0d score=%0d want 1/0/1", step, mode, score); end
      @(negedge clk);
      total++; if (step !== 1'b0 || mode !== 2'd2) begin bad++; $display("FAIL esc_idle step=%0d mode=%0d want 0/2", step, mode); end
   endtask

   task automatic test_reset_mid;
      bit seen = 1'b0;
      send_key(8'h1B);
      @(negedge clk);
      tick = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++; if (mode !== 2'd2 || score !== 8'd0 || dir !== 2'd3) begin bad++; $display("FAIL midrst mode=%0d score=%0d dir=%0d want 2/0/3", mode, score, dir); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tick = 1'b0;
         if (step) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_step got %0d want 0", seen); end
      rst_n = 1'b1;
      send_key(8'h1B);
      do_tick(1'b0);
      total++; if (step !== 1'b1) begin bad++; $display("FAIL pre_rst_step got %0d want 1", step); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (step !== 1'b0 || mode !== 2'd2 || game_over !== 1'b0) begin bad++; $display("FAIL async_rst step=%0d mode=%0d go=%0d want 0/2/0", step, mode, game_over); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_start_run();
      test_queue();
      test_drop();
      test_full();
      test_back_to_back();
      test_pause();
      test_over();
      test_esc_tick();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
